uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Shares the single UART transmitter between NUM_REQ byte requesters using round-robin arbitration. It latches the winning requester's byte and pulses tx_start into the UART. It then waits for tx_done and returns a per-requester completion pulse. A watchdog aborts a transfer whose tx_done never arrives, so a stuck UART cannot lock out the requesters.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 8, byte width carried to the UART
TIMEOUT, 64, max cycles in WAIT_DONE before abort (>=4)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
req  input  NUM_REQ  per-requester level request; held until matching grant
req_data  input  NUM_REQ*DATA_W  packed bytes; slice i belongs to req[i], stable while req[i]=1
grant  output  NUM_REQ  one-hot, 1-cycle pulse: byte of requester i captured
done  output  NUM_REQ  one-hot, 1-cycle pulse: requester i byte transmitted
err  output  1  1-cycle pulse: timeout abort; active_id names the victim
active_id  output  clog2(NUM_REQ)  id of the requester owning the UART (valid when busy=1 or err=1)
busy  output  1  high from grant until done/err inclusive
tx_start  output  1  1-cycle start pulse to the UART
tx_data  output  DATA_W  latched byte to the UART, stable from grant until return to IDLE
tx_busy  input  1  UART transmitter busy
tx_done  input  1  UART transmit-complete pulse

Behaviour:
- All outputs are registered. Reset values: grant=0, done=0, err=0, tx_start=0, tx_data=0, active_id=0, busy=0, state=IDLE, rr pointer ptr=NUM_REQ-1 (requester 0 wins first), timer=0.
- States: IDLE, ISSUE, WAIT_DONE, RELEASE.
- IDLE, with any req bit set:
  - Pick the first set bit searching ptr+1 upward, wrapping modulo NUM_REQ.
  - Next edge: grant[i]=1, tx_data=req_data slice i, active_id=i, busy=1, ptr=i, state -> ISSUE.
- IDLE, with req=0: stay in IDLE.
- ISSUE, with tx_busy=0: next edge tx_start=1, timer=0, state -> WAIT_DONE.
- ISSUE, with tx_busy=1: hold in ISSUE with tx_start=0. The timer does not run in ISSUE.
- WAIT_DONE:
  - tx_start returns to 0 after its single cycle.
  - timer increments each cycle.
  - tx_done=1 -> next edge done[active_id]=1, state -> RELEASE.
  - Else timer==TIMEOUT-1 -> next edge err=1, state -> RELEASE.
  - tx_done and timeout in the same cycle: done wins, no err.
- RELEASE: busy=0 next edge, state -> IDLE. This guarantees at least 1 dead cycle between UART transactions.
- Latency from req seen in IDLE with UART idle:
  - grant at +1
  - tx_start at +2
  - done at +1 after tx_done
  - next grant no earlier than 2 cycles after done.
- Requester protocol:
  - The requester drops req[i] the cycle after grant[i] if it has no further bytes.
  - If req[i] is still high in the next IDLE, it is treated as a new byte, subject to round-robin.
  - req changes after grant have no effect on the in-flight byte.
- Fairness: with all requesters continuously asserted, grants rotate 0,1,...,NUM_REQ-1,0. No requester waits more than NUM_REQ-1 transactions.
- ptr advances on every grant, including transfers later aborted by timeout.
- tx_done arriving outside WAIT_DONE is ignored.
- rst asserted in any state: next edge returns all outputs to reset values. The in-flight byte is dropped with no done and no err pulse.
- timer width is clog2(TIMEOUT); it never wraps because the exit happens at TIMEOUT-1.

Decomposition:
- Shared package uart_pkg holds:
  - arbiter state enumeration (IDLE, ISSUE, WAIT_DONE, RELEASE)
  - default NUM_REQ, DATA_W, TIMEOUT constants
  - an id-width helper function.
- One natural sub-module: uart_rr_pick, a combinational round-robin picker.
  - Inputs: req vector, ptr.
  - Outputs: any_req, winner id, one-hot winner.
  - It is reusable by future RX-side dispatch.

Test Plan:
- Single requester: req=0001, data0=8'hA5, tx_busy=0, tx_done 10 cycles after tx_start -> grant[0] at +1, tx_start at +2 with tx_data=8'hA5, done[0] the cycle after tx_done, busy low after RELEASE.
- All four requesting continuously with data 8'h10,8'h11,8'h12,8'h13 -> grants in order 0,1,2,3,0 with matching tx_data; exactly one tx_start per grant; at least 1 idle cycle between done and next grant.
- Mixed requests: req=1010 after a grant to 1 -> next grant to 3, then 1; requester 0 arriving mid-sequence is served before 1 repeats.
- UART stuck: tx_busy=1 for 20 cycles after grant -> stays in ISSUE, no tx_start until tx_busy=0, no err.
- Timeout: tx_done never asserted, TIMEOUT=64 -> err pulse with active_id correct 64 cycles after tx_start, no done, ptr advanced; a subsequent request is served normally.
- Reset in WAIT_DONE: rst for 1 cycle -> all outputs 0 next edge, no done/err, next request from requester 0 is granted first.
- Collision: tx_done on the same cycle as timer==TIMEOUT-1 -> done pulse only, err stays 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit-side blocks.
//   - arbiter state encoding
//   - default sizing constants
//   - id_width(): bits needed to index n items (minimum 1)
package uart_pkg;

  localparam int unsigned NUM_REQ_DEF = 4;
  localparam int unsigned DATA_W_DEF  = 8;
  localparam int unsigned TIMEOUT_DEF = 64;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2,
    RELEASE   = 2'd3
  } arb_state_e;

  function automatic int unsigned id_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester + UART handshake bundle for uart_tx_arbiter.
//   master : requesters/UART side (drives req, req_data, tx_busy, tx_done)
//   slave  : arbiter side (drives grant, done, err, active_id, busy, tx_start, tx_data)
interface uart_tx_arbiter_if
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF
);
  localparam int unsigned ID_W = id_width(NUM_REQ);

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        grant;
  logic [NUM_REQ-1:0]        done;
  logic                      err;
  logic [ID_W-1:0]           active_id;
  logic                      busy;
  logic                      tx_start;
  logic [DATA_W-1:0]         tx_data;
  logic                      tx_busy;
  logic                      tx_done;

  modport master (
    output req, req_data, tx_busy, tx_done,
    input  grant, done, err, active_id, busy, tx_start, tx_data
  );

  modport slave (
    input  req, req_data, tx_busy, tx_done,
    output grant, done, err, active_id, busy, tx_start, tx_data
  );

endinterface

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first set req bit searching upward
// from ptr+1, wrapping modulo NUM_REQ.
//   req_i       : request vector
//   ptr_i       : id of the last winner
//   any_req_o   : at least one request present
//   winner_id_o : id of the winner (0 when none)
//   winner_oh_o : one-hot winner (0 when none)
module uart_rr_pick
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEF,
  localparam int unsigned ID_W   = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic               any_req_o,
  output logic [ID_W-1:0]    winner_id_o,
  output logic [NUM_REQ-1:0] winner_oh_o
);

  // Offset 1 is checked first and offset NUM_REQ (ptr itself) last.
  always_comb begin
    int unsigned     idx;
    logic [ID_W-1:0] idx_w;
    any_req_o   = 1'b0;
    winner_id_o = '0;
    winner_oh_o = '0;
    idx         = 0;
    idx_w       = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx   = (32'(ptr_i) + k) % NUM_REQ;
      idx_w = ID_W'(idx);
      if (!any_req_o && req_i[idx_w]) begin
        any_req_o          = 1'b1;
        winner_id_o        = idx_w;
        winner_oh_o[idx_w] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte
// requesters, with a watchdog that aborts a transfer whose tx_done never comes.
//   clk : system clock, rising edge
//   rst : synchronous active-high reset
//   bus : requester/UART bundle (slave modport)
//         in : req, req_data, tx_busy, tx_done
//         out: grant, done, err, active_id, busy, tx_start, tx_data (all registered)
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  uart_tx_arbiter_if.slave bus
);

  localparam int unsigned ID_W    = id_width(NUM_REQ);
  localparam int unsigned TIMER_W = id_width(TIMEOUT);

  arb_state_e          state_q, state_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [NUM_REQ-1:0]  done_q, done_d;
  logic                err_q, err_d;
  logic                tx_start_q, tx_start_d;
  logic [DATA_W-1:0]   tx_data_q, tx_data_d;
  logic [ID_W-1:0]     active_id_q, active_id_d;
  logic                busy_q, busy_d;

  logic                pick_any;
  logic [ID_W-1:0]     pick_id;
  logic [NUM_REQ-1:0]  pick_oh;

  uart_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req_i       (bus.req),
    .ptr_i       (ptr_q),
    .any_req_o   (pick_any),
    .winner_id_o (pick_id),
    .winner_oh_o (pick_oh)
  );

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= ID_W'(NUM_REQ - 1);
      timer_q     <= '0;
      grant_q     <= '0;
      done_q      <= '0;
      err_q       <= 1'b0;
      tx_start_q  <= 1'b0;
      tx_data_q   <= '0;
      active_id_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      timer_q     <= timer_d;
      grant_q     <= grant_d;
      done_q      <= done_d;
      err_q       <= err_d;
      tx_start_q  <= tx_start_d;
      tx_data_q   <= tx_data_d;
      active_id_q <= active_id_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state and next-output logic; pulses default low every cycle.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    timer_d     = timer_q;
    grant_d     = '0;
    done_d      = '0;
    err_d       = 1'b0;
    tx_start_d  = 1'b0;
    tx_data_d   = tx_data_q;
    active_id_d = active_id_q;
    busy_d      = busy_q;

    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d     = pick_oh;
          active_id_d = pick_id;
          busy_d      = 1'b1;
          ptr_d       = pick_id;
          state_d     = ISSUE;
          // Constant-index mux keeps the byte select free of variable slicing.
          for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (pick_oh[i]) tx_data_d = bus.req_data[i*DATA_W +: DATA_W];
          end
        end
      end
      ISSUE: begin
        if (!bus.tx_busy) begin
          tx_start_d = 1'b1;
          timer_d    = '0;
          state_d    = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        timer_d = timer_q + TIMER_W'(1);
        // tx_done takes priority over a coincident timeout.
        if (bus.tx_done) begin
          done_d[active_id_q] = 1'b1;
          state_d             = RELEASE;
        end else if (timer_q == TIMER_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.grant     = grant_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.tx_start  = tx_start_q;
  assign bus.tx_data   = tx_data_q;
  assign bus.active_id = active_id_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (NUM_REQ=4, DATA_W=8, TIMEOUT=64).
module tb_uart_tx_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(4), .DATA_W(8)) bus ();

  uart_tx_arbiter #(.NUM_REQ(4), .DATA_W(8), .TIMEOUT(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_grant"}, 32'(bus.grant), 32'h0);
    chk({tag, "_done"}, 32'(bus.done), 32'h0);
    chk({tag, "_err"}, 32'(bus.err), 32'h0);
    chk({tag, "_tx_start"}, 32'(bus.tx_start), 32'h0);
    chk({tag, "_tx_data"}, 32'(bus.tx_data), 32'h0);
    chk({tag, "_active_id"}, 32'(bus.active_id), 32'h0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'h0);
  endtask

  // One full transaction starting with the arbiter in IDLE and req set.
  // drop/add modify req right after the grant; stall holds tx_busy in ISSUE;
  // delay is the number of WAIT_DONE cycles before tx_done is raised.
  task automatic serve(input int id, input logic [7:0] data, input logic [3:0] drop,
                       input logic [3:0] add, input int stall, input int delay);
    logic [3:0] oh;
    oh = 4'(1 << id);
    bus.tx_busy = (stall != 0);
    step();
    chk($sformatf("grant%0d", id), 32'(bus.grant), 32'(oh));
    chk($sformatf("active_id%0d", id), 32'(bus.active_id), 32'(id));
    chk($sformatf("tx_data%0d", id), 32'(bus.tx_data), 32'(data));
    chk("busy_at_grant", 32'(bus.busy), 32'h1);
    chk("no_start_at_grant", 32'(bus.tx_start), 32'h0);
    bus.req = (bus.req & ~drop) | add;
    for (int s = 0; s < stall; s++) begin
      step();
      chk("stall_no_start", 32'(bus.tx_start), 32'h0);
      chk("stall_no_err", 32'(bus.err), 32'h0);
    end
    bus.tx_busy = 1'b0;
    step();
    chk("tx_start", 32'(bus.tx_start), 32'h1);
    chk("tx_data_at_start", 32'(bus.tx_data), 32'(data));
    chk("grant_cleared", 32'(bus.grant), 32'h0);
    for (int d = 0; d < delay; d++) begin
      step();
      chk("single_start", 32'(bus.tx_start), 32'h0);
      chk("wait_no_err", 32'(bus.err), 32'h0);
    end
    bus.tx_done = 1'b1;
    step();
    bus.tx_done = 1'b0;
    chk($sformatf("done%0d", id), 32'(bus.done), 32'(oh));
    chk("done_no_err", 32'(bus.err), 32'h0);
    chk("busy_at_done", 32'(bus.busy), 32'h1);
    step();
    chk("busy_after_release", 32'(bus.busy), 32'h0);
    chk("done_one_cycle", 32'(bus.done), 32'h0);
    chk("dead_cycle_no_grant", 32'(bus.grant), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.req      = 4'b0000;
    bus.req_data = {8'h13, 8'h12, 8'h11, 8'h10};
    bus.tx_busy  = 1'b0;
    bus.tx_done  = 1'b0;

    // Reset values
    rst = 1'b1;
    step();
    step();
    chk_idle_outputs("reset");
    rst = 1'b0;
    step();
    chk("idle_no_grant", 32'(bus.grant), 32'h0);

    // All four continuously requesting: 0,1,2,3,0
    bus.req = 4'b1111;
    serve(0, 8'h10, 4'b0000, 4'b0000, 0, 2);
    serve(1, 8'h11, 4'b0000, 4'b0000, 0, 2);
    serve(2, 8'h12, 4'b0000, 4'b0000, 0, 2);
    serve(3, 8'h13, 4'b0000, 4'b0000, 0, 2);
    serve(0, 8'h10, 4'b1111, 4'b0000, 0, 2);

    // Single requester, tx_done 10 cycles after tx_start
    bus.req_data = {8'h13, 8'h12, 8'h11, 8'hA5};
    bus.req = 4'b0001;
    serve(0, 8'hA5, 4'b0001, 4'b0000, 0, 9);
    bus.req_data = {8'h13, 8'h12, 8'h11, 8'h10};

    // tx_done while idle is ignored
    bus.tx_done = 1'b1;
    step();
    bus.tx_done = 1'b0;
    chk("stray_tx_done", 32'(bus.done), 32'h0);

    // Mixed: 1010 -> 1, 3 (0 arrives), 0, then 1 again
    bus.req = 4'b1010;
    serve(1, 8'h11, 4'b0000, 4'b0000, 0, 1);
    serve(3, 8'h13, 4'b1000, 4'b0001, 0, 1);
    serve(0, 8'h10, 4'b0001, 4'b0000, 0, 1);
    serve(1, 8'h11, 4'b0010, 4'b0000, 0, 1);

    // UART busy for 20 cycles after grant
    bus.req = 4'b0100;
    serve(2, 8'h12, 4'b0100, 4'b0000, 20, 3);

    // Timeout on requester 3
    bus.req = 4'b1000;
    step();
    chk("to_grant", 32'(bus.grant), 32'h8);
    bus.req = 4'b0000;
    step();
    chk("to_tx_start", 32'(bus.tx_start), 32'h1);
    for (int c = 0; c < 63; c++) begin
      step();
      chk("to_no_err_early", 32'(bus.err), 32'h0);
    end
    step();
    chk("to_err", 32'(bus.err), 32'h1);
    chk("to_err_id", 32'(bus.active_id), 32'h3);
    chk("to_no_done", 32'(bus.done), 32'h0);
    chk("to_busy", 32'(bus.busy), 32'h1);
    step();
    chk("to_err_pulse", 32'(bus.err), 32'h0);
    chk("to_busy_low", 32'(bus.busy), 32'h0);

    // Pointer advanced past 3: 0 wins over 3, then 3
    bus.req = 4'b1001;
    serve(0, 8'h10, 4'b0001, 4'b0000, 0, 2);
    serve(3, 8'h13, 4'b1000, 4'b0000, 0, 2);

    // Collision: tx_done on the timer==TIMEOUT-1 cycle
    bus.req = 4'b0100;
    serve(2, 8'h12, 4'b0100, 4'b0000, 0, 63);

    // Reset during WAIT_DONE
    bus.req = 4'b0010;
    step();
    chk("rst_case_grant", 32'(bus.grant), 32'h2);
    bus.req = 4'b0000;
    step();
    chk("rst_case_start", 32'(bus.tx_start), 32'h1);
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_idle_outputs("rst_wait");
    for (int c = 0; c < 4; c++) begin
      step();
      chk("post_rst_no_done", 32'(bus.done), 32'h0);
      chk("post_rst_no_err", 32'(bus.err), 32'h0);
    end
    bus.req = 4'b1111;
    serve(0, 8'h10, 4'b1111, 4'b0000, 0, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
